// File: rtl/fpu_conv_issue_if.sv
// rtl/fpu_conv_issue_if.sv - core request/response and conversion-unit handshake bundle
interface fpu_conv_issue_if;
    logic        req;
    logic [1:0]  op;
    logic [31:0] src;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;
    logic [31:0] itof_a;
    logic [31:0] ftoi_a;
    logic        itof_en;
    logic        ftoi_en;
    logic [31:0] itof_res;
    logic [31:0] ftoi_res;
    logic        itof_ready;
    logic        ftoi_ready;

    modport slave (
        input  req, op, src, itof_res, ftoi_res, itof_ready, ftoi_ready,
        output busy, done, err, result, itof_a, ftoi_a, itof_en, ftoi_en
    );

    modport master (
        output req, op, src, itof_res, ftoi_res, itof_ready, ftoi_ready,
        input  busy, done, err, result, itof_a, ftoi_a, itof_en, ftoi_en
    );
endinterface

// File: rtl/fpu_conv_issue.sv
// rtl/fpu_conv_issue.sv - issue/collect controller for the itof and ftoi conversion units
module fpu_conv_issue #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rstn,
    fpu_conv_issue_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [7:0]  WAIT_LAST = 8'(WAIT_MAX - 1);
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] INT_MIN_F = 32'hCF00_0000;

    state_t      state;
    logic        sel_ftoi;
    logic [7:0]  wait_cnt;
    logic        done_q;
    logic        err_q;
    logic [31:0] result_q;
    logic [31:0] itof_a_q;
    logic [31:0] ftoi_a_q;
    logic        itof_en_q;
    logic        ftoi_en_q;

    logic        sel_ready;
    logic [31:0] sel_res;

    // Only the unit that was issued is listened to; the other one's ready is noise.
    assign sel_ready = sel_ftoi ? bus.ftoi_ready : bus.itof_ready;
    assign sel_res   = sel_ftoi ? bus.ftoi_res   : bus.itof_res;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            sel_ftoi  <= 1'b0;
            wait_cnt  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
            itof_a_q  <= '0;
            ftoi_a_q  <= '0;
            itof_en_q <= 1'b0;
            ftoi_en_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            itof_en_q <= 1'b0;
            ftoi_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        if (bus.op[1]) begin
                            done_q   <= 1'b1;
                            err_q    <= 1'b1;
                            result_q <= '0;
                        end else if (!bus.op[0] && bus.src == INT_MIN) begin
                            // The one's-complement itof datapath cannot represent -2^31.
                            done_q   <= 1'b1;
                            err_q    <= 1'b0;
                            result_q <= INT_MIN_F;
                        end else if (!bus.op[0] && bus.src == '0) begin
                            done_q   <= 1'b1;
                            err_q    <= 1'b0;
                            result_q <= '0;
                        end else begin
                            sel_ftoi <= bus.op[0];
                            if (bus.op[0]) begin
                                ftoi_a_q  <= bus.src;
                                ftoi_en_q <= 1'b1;
                            end else begin
                                itof_a_q  <= bus.src;
                                itof_en_q <= 1'b1;
                            end
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (sel_ready) begin
                        result_q <= sel_res;
                        done_q   <= 1'b1;
                        err_q    <= 1'b0;
                        state    <= IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        result_q <= '0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.result  = result_q;
    assign bus.itof_a  = itof_a_q;
    assign bus.ftoi_a  = ftoi_a_q;
    assign bus.itof_en = itof_en_q;
    assign bus.ftoi_en = ftoi_en_q;
endmodule

// File: tb/tb_fpu_conv_issue.sv
// tb/tb_fpu_conv_issue.sv - self-checking bench for fpu_conv_issue
module tb_fpu_conv_issue;
    localparam int WMAX = 15;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src = '0;
    logic [31:0] itof_res_v = '0;
    logic [31:0] ftoi_res_v = '0;
    logic        man_itof_ready = 1'b0;
    logic        man_ftoi_ready = 1'b0;
    int          itof_dly = 0;
    int          ftoi_dly = 0;
    int          itof_cnt;
    int          ftoi_cnt;
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fpu_conv_issue_if bus ();

    fpu_conv_issue #(.WAIT_MAX(WMAX)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    assign bus.req        = req;
    assign bus.op         = op;
    assign bus.src        = src;
    assign bus.itof_res   = itof_res_v;
    assign bus.ftoi_res   = ftoi_res_v;
    assign bus.itof_ready = man_itof_ready | (itof_cnt == 1);
    assign bus.ftoi_ready = man_ftoi_ready | (ftoi_cnt == 1);

    // Unit stand-ins: ready appears dly cycles after the en cycle (dly 0 = never).
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            itof_cnt <= 0;
            ftoi_cnt <= 0;
        end else begin
            if (bus.itof_en && itof_dly != 0) itof_cnt <= itof_dly;
            else if (itof_cnt != 0)           itof_cnt <= itof_cnt - 1;
            if (bus.ftoi_en && ftoi_dly != 0) ftoi_cnt <= ftoi_dly;
            else if (ftoi_cnt != 0)           ftoi_cnt <= ftoi_cnt - 1;
        end
    end

    // Transaction-level model: m_age counts edges since the accepting edge.
    logic        m_active, m_sel;
    int          m_age;
    logic        exp_busy, exp_done, exp_err, exp_itof_en, exp_ftoi_en;
    logic [31:0] exp_result, exp_itof_a, exp_ftoi_a;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active <= 1'b0; m_sel <= 1'b0; m_age <= 0;
            exp_busy <= 1'b0; exp_done <= 1'b0; exp_err <= 1'b0;
            exp_itof_en <= 1'b0; exp_ftoi_en <= 1'b0;
            exp_result <= '0; exp_itof_a <= '0; exp_ftoi_a <= '0;
        end else begin
            exp_done    <= 1'b0;
            exp_itof_en <= 1'b0;
            exp_ftoi_en <= 1'b0;
            if (!m_active) begin
                if (req) begin
                    if (op >= 2) begin
                        exp_done <= 1'b1; exp_err <= 1'b1; exp_result <= 0;
                    end else if (op == 0 && src == 32'h8000_0000) begin
                        exp_done <= 1'b1; exp_err <= 1'b0; exp_result <= 32'hCF00_0000;
                    end else if (op == 0 && src == 0) begin
                        exp_done <= 1'b1; exp_err <= 1'b0; exp_result <= 0;
                    end else begin
                        m_active <= 1'b1; m_sel <= (op == 1); m_age <= 1; exp_busy <= 1'b1;
                        if (op == 1) begin exp_ftoi_en <= 1'b1; exp_ftoi_a <= src; end
                        else         begin exp_itof_en <= 1'b1; exp_itof_a <= src; end
                    end
                end
            end else begin
                m_age <= m_age + 1;
                if (m_age >= 2 && (m_sel ? bus.ftoi_ready : bus.itof_ready)) begin
                    m_active <= 1'b0; exp_busy <= 1'b0;
                    exp_done <= 1'b1; exp_err <= 1'b0;
                    exp_result <= m_sel ? ftoi_res_v : itof_res_v;
                end else if (m_age == WMAX + 1) begin
                    m_active <= 1'b0; exp_busy <= 1'b0;
                    exp_done <= 1'b1; exp_err <= 1'b1; exp_result <= 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("busy",    32'(bus.busy),    32'(exp_busy));
            chk("done",    32'(bus.done),    32'(exp_done));
            chk("result",  bus.result,       exp_result);
            chk("itof_en", 32'(bus.itof_en), 32'(exp_itof_en));
            chk("ftoi_en", 32'(bus.ftoi_en), 32'(exp_ftoi_en));
            chk("itof_a",  bus.itof_a,       exp_itof_a);
            chk("ftoi_a",  bus.ftoi_a,       exp_ftoi_a);
            if (exp_done) chk("err", 32'(bus.err), 32'(exp_err));
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] s);
        @(posedge clk); #1;
        req = 1'b1; op = o; src = s;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic [31:0] r, output logic e);
        lat = 0; r = '0; e = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i; r = bus.result; e = bus.err;
                break;
            end
        end
    endtask

    task automatic check_done(input string name, input int exp_lat,
                              input logic [31:0] exp_r, input logic exp_e);
        int lat; logic [31:0] r; logic e;
        wait_done(lat, r, e);
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_result"}, r, exp_r);
        chk({name, "_err"}, 32'(e), 32'(exp_e));
    endtask

    task automatic quiet(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(name, 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(bus.busy), 32'd0);
        chk("rst_done",   32'(bus.done), 32'd0);
        chk("rst_result", bus.result,    32'd0);
        chk("rst_en",     32'({bus.itof_en, bus.ftoi_en}), 32'd0);
        @(posedge clk); #1 rstn = 1'b1;

        // Normal itof: 5 -> 5.0f, done three cycles after the request edge
        itof_dly = 1; itof_res_v = 32'h40A0_0000;
        issue(2'b00, 32'h0000_0005);
        check_done("itof5", 3, 32'h40A0_0000, 1'b0);

        // Back-to-back bypasses; the second req lands in the done cycle of the first
        @(posedge clk); #1 req = 1'b1; op = 2'b00; src = 32'h8000_0000;
        @(posedge clk); #1 src = 32'h0;
        @(negedge clk);
        chk("byp_min_done",   32'(bus.done), 32'd1);
        chk("byp_min_result", bus.result,    32'hCF00_0000);
        chk("byp_min_busy",   32'(bus.busy), 32'd0);
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        chk("byp_zero_done",   32'(bus.done), 32'd1);
        chk("byp_zero_result", bus.result,    32'h0);

        // ftoi with a spurious itof ready during WAIT
        itof_dly = 0; itof_res_v = 32'hDEAD_BEEF;
        ftoi_dly = 2; ftoi_res_v = 32'h0000_0002;
        issue(2'b01, 32'h3FC0_0000);
        fork
            begin
                @(posedge clk); #1 man_itof_ready = 1'b1;
                @(posedge clk); #1 man_itof_ready = 1'b0;
            end
        join_none
        check_done("ftoi", 4, 32'h0000_0002, 1'b0);

        // Illegal op, then a req dropped while busy
        check_illegal: begin
            issue(2'b10, 32'h0000_007B);
            check_done("illegal", 1, 32'h0, 1'b1);
        end
        itof_dly = 1; itof_res_v = 32'h40A0_0000;
        issue(2'b00, 32'h0000_0005);
        fork
            begin
                req = 1'b1; op = 2'b10;
                @(posedge clk); #1 req = 1'b0;
            end
        join_none
        check_done("drop", 3, 32'h40A0_0000, 1'b0);
        quiet("drop_no_extra", 3);

        // Unit never answers: timeout after ISSUE plus WMAX WAIT cycles
        itof_dly = 0;
        issue(2'b00, 32'h0000_0007);
        check_done("timeout", WMAX + 2, 32'h0, 1'b1);
        @(posedge clk); #1 man_itof_ready = 1'b1;
        @(posedge clk); #1 man_itof_ready = 1'b0;
        quiet("late_ready", 2);

        // Reset while in WAIT
        issue(2'b00, 32'h0000_0009);
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_busy",   32'(bus.busy),   32'd0);
        chk("mid_rst_itof_a", bus.itof_a,      32'd0);
        chk("mid_rst_done",   32'(bus.done),   32'd0);
        chk("mid_rst_result", bus.result,      32'd0);
        chk("mid_rst_en",     32'(bus.itof_en), 32'd0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1 man_itof_ready = 1'b1;
        @(posedge clk); #1 man_itof_ready = 1'b0;
        quiet("post_rst_ready", 2);
        itof_dly = 1; itof_res_v = 32'h40A0_0000;
        issue(2'b00, 32'h0000_0005);
        check_done("after_rst", 3, 32'h40A0_0000, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
